hht_mem_responder: RTL
======================

Name: hht_mem_responder

Overview:
Memory-side responder for the HHT control block's two read streams. Port 1 serves column-index/data fetches (addr1/dataIn1 side); port 2 serves vector-value fetches (addr2/dataIn2 side). Both ports share one single-ported word RAM through a round-robin arbiter, with a fixed-latency read pipeline. A write port lets the CPU/bench preload the RAM. This block replaces the combinational case-statement memory with a cycle-accurate synthesizable responder.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, request address width
DEPTH, 512, number of RAM words
BASE, 0, word address mapped to RAM entry 0
RD_LAT, 2, grant-to-valid latency in cycles; legal range 1..4
DEFAULT_DATA, 99999, data returned for out-of-range reads

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
WR  in  1  write strobe
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
req1  in  1  port-1 read request
addr1  in  ADDR_W  port-1 read address
gnt1  out  1  port-1 request accepted this cycle (combinational)
dataOut1  out  DATA_W  port-1 read data
valid1  out  1  dataOut1 valid, one-cycle pulse
req2, addr2, gnt2, dataOut2, valid2: same as port 1, for port 2
rd_cnt1, rd_cnt2, oob_cnt  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset: valid1/valid2=0, dataOut1/dataOut2=0, pipeline emptied, round-robin pointer set to favour port 1, stats=0. RAM contents are not reset. Assertion mid-operation discards in-flight reads; no valid is issued for them.
- Arbitration is evaluated per cycle and is combinational on the request inputs:
  - WR has absolute priority. A WR cycle writes RAM at the edge, and gnt1=gnt2=0.
  - Otherwise, with a single requester, that requester is granted.
  - With both requesting, the port not served last is granted. The pointer updates only on a read grant.
- A request is held by the requester until its gnt is seen. A requester may drop an ungranted request without penalty.
- Granted read: the address is sampled at the grant edge. An out-of-range address (addr < BASE or addr >= BASE+DEPTH) yields DEFAULT_DATA and no RAM access. Otherwise the read returns RAM[addr-BASE].
- Pipeline: RD_LAT stages, each carrying {valid, port_id, data}. validN pulses high exactly RD_LAT cycles after the grant edge, with dataOutN updated in the same cycle. dataOutN holds its last value when validN is low.
- Throughput: one read per cycle in total. Back-to-back grants produce back-to-back valids in grant order.
- Read-after-write: a write at edge k is visible to any read granted at edge k+1 or later. Same-cycle conflict cannot occur because WR blocks grants.
- Write to an out-of-range address is silently dropped.
- Only the low DATA_W bits are stored. No wrap-around of addresses modulo DEPTH.

Optional Feature:
MEM_STATS_EN:
- Defined: rd_cnt1 and rd_cnt2 count granted reads per port. oob_cnt counts out-of-range reads and writes. All three are 16-bit, saturate at 0xFFFF, and are cleared by Rst.
- Undefined: all three outputs are tied to 0 and no counter logic is built.

Test Plan:
- Preload via WR: write 15 to addr 180 and 2 to addr 181; req1 with addr1=180 -> gnt1 same cycle; after RD_LAT=2 cycles, valid1=1 and dataOut1=15. A following read of addr1=181 -> dataOut1=2 one cycle later.
- Both ports request continuously (addr1=180, addr2=2, where RAM[2]=7) -> grants alternate 1,2,1,2. Valids alternate: dataOut1=15, dataOut2=7, each on a one-cycle pulse.
- WR asserted while req1 and req2 are high -> gnt1=gnt2=0 for that cycle. The next-cycle read of the written address returns the new data.
- Out-of-range read with addr2=600 (DEPTH=512, BASE=0) -> valid2 after RD_LAT cycles, dataOut2=99999; with MEM_STATS_EN, oob_cnt=1.
- Rst asserted one cycle after a grant -> no valid pulse, dataOut1=0, pointer favours port 1. RAM still returns preloaded values after reset.
- RD_LAT=4 build, 8 back-to-back port-1 reads of addresses 180..187 -> 8 consecutive valid1 pulses starting 4 cycles after the first grant, data in address order; with MEM_STATS_EN, rd_cnt1=8.

Source files
------------

// File: rtl/hht_mem_responder_if.sv
// Request/response bundle between the HHT control block (master) and hht_mem_responder (slave).
// Handshake: reqN/addrN are held by the master until gntN is seen high in the same cycle; a grant
// completes at that rising edge. validN is a one-cycle pulse with dataOutN; there is no back-pressure.
interface hht_mem_responder_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              WR;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic              gnt1;
   logic [DATA_W-1:0] dataOut1;
   logic              valid1;
   logic              req2;
   logic [ADDR_W-1:0] addr2;
   logic              gnt2;
   logic [DATA_W-1:0] dataOut2;
   logic              valid2;
   logic [15:0]       rd_cnt1;
   logic [15:0]       rd_cnt2;
   logic [15:0]       oob_cnt;

   modport master (
      output WR, waddr, wdata, req1, addr1, req2, addr2,
      input  gnt1, dataOut1, valid1, gnt2, dataOut2, valid2, rd_cnt1, rd_cnt2, oob_cnt
   );

   modport slave (
      input  WR, waddr, wdata, req1, addr1, req2, addr2,
      output gnt1, dataOut1, valid1, gnt2, dataOut2, valid2, rd_cnt1, rd_cnt2, oob_cnt
   );
endinterface

// File: rtl/hht_mem_responder.sv
// Two-port round-robin read responder over one single-ported word RAM, fixed RD_LAT read pipeline.
// Optional statistics counters are built when MEM_STATS_EN is defined.
module hht_mem_responder #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 512,
   parameter int BASE         = 0,
   parameter int RD_LAT       = 2,
   parameter int DEFAULT_DATA = 99999
) (
   input logic                 Clk,
   input logic                 Rst,
   hht_mem_responder_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LO_X = (ADDR_W+1)'(BASE);
   localparam logic [ADDR_W:0] HI_X = (ADDR_W+1)'(BASE + DEPTH);
   localparam logic [DATA_W-1:0] DEF_DATA = DATA_W'(DEFAULT_DATA);

   typedef struct packed {
      logic              v;
      logic              port;   // 0: port 1, 1: port 2
      logic [DATA_W-1:0] data;
   } stage_t;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= LO_X) && ({1'b0, a} < HI_X);
   endfunction

   function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - ADDR_W'(BASE);
      return off[IDX_W-1:0];
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   stage_t            pipe_q [RD_LAT];
   stage_t            pipe_d [RD_LAT];
   stage_t            last_d;
   logic              ptr_q, ptr_d;   // 0: favour port 1, 1: favour port 2
   logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
   logic              gnt1, gnt2, rd_hit, wr_hit;
   logic [ADDR_W-1:0] rd_addr;

   always_comb begin
      // A write cycle blocks both grants, so the RAM never sees a read and a write together.
      gnt1    = !bus.WR && bus.req1 && (!bus.req2 || !ptr_q);
      gnt2    = !bus.WR && bus.req2 && (!bus.req1 || ptr_q);
      rd_addr = gnt2 ? bus.addr2 : bus.addr1;
      rd_hit  = in_range(rd_addr);
      wr_hit  = bus.WR && in_range(bus.waddr);

      ptr_d = ptr_q;
      if (gnt1)      ptr_d = 1'b1;
      else if (gnt2) ptr_d = 1'b0;

      pipe_d[0].v    = gnt1 || gnt2;
      pipe_d[0].port = gnt2;
      pipe_d[0].data = rd_hit ? mem_q[to_idx(rd_addr)] : DEF_DATA;
      for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

      // Output data registers load alongside the final stage and hold between pulses.
      last_d  = pipe_d[RD_LAT-1];
      data1_d = data1_q;
      data2_d = data2_q;
      if (last_d.v && !last_d.port) data1_d = last_d.data;
      if (last_d.v &&  last_d.port) data2_d = last_d.data;
   end

   always_ff @(posedge Clk) begin
      if (wr_hit) mem_q[to_idx(bus.waddr)] <= bus.wdata;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ptr_q   <= 1'b0;
         data1_q <= '0;
         data2_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
         ptr_q   <= ptr_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         pipe_q  <= pipe_d;
      end
   end

   assign bus.gnt1     = gnt1;
   assign bus.gnt2     = gnt2;
   assign bus.valid1   = pipe_q[RD_LAT-1].v && !pipe_q[RD_LAT-1].port;
   assign bus.valid2   = pipe_q[RD_LAT-1].v &&  pipe_q[RD_LAT-1].port;
   assign bus.dataOut1 = data1_q;
   assign bus.dataOut2 = data2_q;

`ifdef MEM_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
      return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
   endfunction

   logic [15:0] rd_cnt1_q, rd_cnt1_d, rd_cnt2_q, rd_cnt2_d, oob_cnt_q, oob_cnt_d;

   always_comb begin
      rd_cnt1_d = sat_inc(rd_cnt1_q, gnt1);
      rd_cnt2_d = sat_inc(rd_cnt2_q, gnt2);
      oob_cnt_d = sat_inc(oob_cnt_q, ((gnt1 || gnt2) && !rd_hit) || (bus.WR && !wr_hit));
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rd_cnt1_q <= '0;
         rd_cnt2_q <= '0;
         oob_cnt_q <= '0;
      end else begin
         rd_cnt1_q <= rd_cnt1_d;
         rd_cnt2_q <= rd_cnt2_d;
         oob_cnt_q <= oob_cnt_d;
      end
   end

   assign bus.rd_cnt1 = rd_cnt1_q;
   assign bus.rd_cnt2 = rd_cnt2_q;
   assign bus.oob_cnt = oob_cnt_q;
`else
   assign bus.rd_cnt1 = '0;
   assign bus.rd_cnt2 = '0;
   assign bus.oob_cnt = '0;
`endif
endmodule
